// File: rtl/t03_mc_control.sv
// Multi-cycle RV32I control unit. Walks each instruction through
// FETCH -> FWAIT -> DECODE -> EXEC -> (MEM -> MWAIT) -> WB, talks to the
// memory bus with a bounded ack wait, and latches the decoded control
// fields for the datapath once per instruction.
module t03_mc_control #(
    parameter int ENABLE_M     = 1,
    parameter int TIMEOUT      = 16,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7bit6,
    input  logic       funct7bit0,
    input  logic       ack,
    output logic       fetchReq,
    output logic       memReq,
    output logic       instrLatch,
    output logic       pcEnable,
    output logic [2:0] branch,
    output logic [1:0] jump,
    output logic       memRead,
    output logic       memWrite,
    output logic       memToReg,
    output logic [4:0] ALUOp,
    output logic       ALUsrc,
    output logic       auipc,
    output logic       lui,
    output logic [2:0] dataWidth,
    output logic       regWrite,
    output logic       illegal,
    output logic       halted,
    output logic       busError,
    output logic [2:0] state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_FWAIT  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_MWAIT  = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_STOP   = 3'd7;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ZERO   = 7'b0000000;

    // Last counter value tolerated while waiting for ack.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] next_state;
    logic [7:0] wait_count;
    logic [7:0] next_count;

    // Instruction class bits kept alongside the visible decoded fields.
    logic is_load;
    logic is_store;
    logic writes_rd;

    logic       dec_illegal;
    logic       dec_halt;
    logic       dec_load;
    logic       dec_store;
    logic       dec_writes;
    logic [4:0] dec_aluop;
    logic       dec_alusrc;
    logic [2:0] dec_branch;
    logic [1:0] dec_jump;
    logic       dec_memtoreg;
    logic       dec_auipc;
    logic       dec_lui;
    logic [2:0] dec_width;

    // Combinational instruction decode; only sampled in DECODE.
    always_comb begin
        dec_illegal  = 1'b0;
        dec_halt     = 1'b0;
        dec_load     = 1'b0;
        dec_store    = 1'b0;
        dec_writes   = 1'b0;
        dec_aluop    = 5'b00000;
        dec_alusrc   = 1'b0;
        dec_branch   = 3'b011;
        dec_jump     = 2'b00;
        dec_memtoreg = 1'b0;
        dec_auipc    = 1'b0;
        dec_lui      = 1'b0;
        dec_width    = 3'b000;
        case (opcode)
            OP_RTYPE: begin
                if (funct7bit0) begin
                    if (ENABLE_M != 0) begin
                        dec_aluop  = {1'b1, 1'b0, funct3};
                        dec_writes = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    dec_aluop  = {1'b0, funct7bit6, funct3};
                    dec_writes = 1'b1;
                end
            end
            OP_IALU: begin
                dec_aluop  = {1'b0, (funct3 == 3'd5) & funct7bit6, funct3};
                dec_alusrc = 1'b1;
                dec_writes = 1'b1;
            end
            OP_LOAD: begin
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_load     = 1'b1;
                dec_width    = funct3;
                dec_writes   = 1'b1;
            end
            OP_STORE: begin
                dec_alusrc = 1'b1;
                dec_store  = 1'b1;
                dec_width  = funct3;
            end
            OP_BRANCH: begin
                dec_branch = funct3;
                dec_aluop  = 5'b01000;
            end
            OP_JAL: begin
                dec_jump   = 2'b01;
                dec_writes = 1'b1;
            end
            OP_JALR: begin
                dec_jump   = 2'b10;
                dec_alusrc = 1'b1;
                dec_writes = 1'b1;
            end
            OP_LUI: begin
                dec_lui    = 1'b1;
                dec_alusrc = 1'b1;
                dec_writes = 1'b1;
            end
            OP_AUIPC: begin
                dec_auipc  = 1'b1;
                dec_alusrc = 1'b1;
                dec_writes = 1'b1;
            end
            OP_ZERO: begin
                if (HALT_ON_ZERO != 0) begin
                    dec_halt = 1'b1;
                end
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // An undecodable instruction hands the datapath an all-zero field set.
        if (dec_illegal) begin
            dec_writes   = 1'b0;
            dec_load     = 1'b0;
            dec_store    = 1'b0;
            dec_aluop    = 5'b00000;
            dec_alusrc   = 1'b0;
            dec_branch   = 3'b000;
            dec_jump     = 2'b00;
            dec_memtoreg = 1'b0;
            dec_auipc    = 1'b0;
            dec_lui      = 1'b0;
            dec_width    = 3'b000;
        end
    end

    // Next-state and ack-wait counter logic.
    always_comb begin
        next_state = state;
        next_count = wait_count;
        case (state)
            S_FETCH: begin
                next_state = S_FWAIT;
                next_count = 8'd0;
            end
            S_FWAIT, S_MWAIT: begin
                if (ack) begin
                    next_state = (state == S_FWAIT) ? S_DECODE : S_WB;
                    next_count = 8'd0;
                end else if (wait_count == WAIT_LAST) begin
                    next_state = S_STOP;
                    next_count = 8'd0;
                end else begin
                    next_count = wait_count + 8'd1;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    next_state = S_WB;
                end else if (dec_halt) begin
                    next_state = S_STOP;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                next_state = S_MWAIT;
                next_count = 8'd0;
            end
            S_WB: begin
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_STOP;
            end
        endcase
    end

    // State, wait counter and the sticky halt/bus-error flags; en=0 freezes all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            wait_count <= 8'd0;
            halted     <= 1'b0;
            busError   <= 1'b0;
        end else if (en) begin
            state      <= next_state;
            wait_count <= next_count;
            if (state == S_DECODE && next_state == S_STOP) begin
                halted <= 1'b1;
            end
            if ((state == S_FWAIT || state == S_MWAIT) && next_state == S_STOP) begin
                busError <= 1'b1;
            end
        end
    end

    // Decoded fields are captured once in DECODE and held for the instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch    <= 3'b011;
            jump      <= 2'b00;
            memToReg  <= 1'b0;
            ALUOp     <= 5'b00000;
            ALUsrc    <= 1'b0;
            auipc     <= 1'b0;
            lui       <= 1'b0;
            dataWidth <= 3'b000;
            is_load   <= 1'b0;
            is_store  <= 1'b0;
            writes_rd <= 1'b0;
        end else if (en && state == S_DECODE) begin
            branch    <= dec_branch;
            jump      <= dec_jump;
            memToReg  <= dec_memtoreg;
            ALUOp     <= dec_aluop;
            ALUsrc    <= dec_alusrc;
            auipc     <= dec_auipc;
            lui       <= dec_lui;
            dataWidth <= dec_width;
            is_load   <= dec_load;
            is_store  <= dec_store;
            writes_rd <= dec_writes;
        end
    end

    // Bus requests follow the state (and drop the moment rst rises);
    // one-cycle strobes are additionally gated by en.
    always_comb begin
        fetchReq   = !rst && (state == S_FETCH || state == S_FWAIT);
        memReq     = (state == S_MEM || state == S_MWAIT);
        memRead    = memReq && is_load;
        memWrite   = memReq && is_store;
        instrLatch = en && (state == S_FWAIT) && ack;
        pcEnable   = en && (state == S_WB);
        regWrite   = en && (state == S_WB) && writes_rd;
        illegal    = en && (state == S_DECODE) && dec_illegal;
    end

endmodule

// File: tb/tb_t03_mc_control.sv
// Directed bench for t03_mc_control: a decode vector table run on the
// default configuration, plus hand sequences for reset, delayed ack,
// enable freeze, bus timeout, halt, and a second instance with
// ENABLE_M=0 / HALT_ON_ZERO=0 / TIMEOUT=4.
`timescale 1ns/1ps
module tb_t03_mc_control;

    typedef struct packed {
        logic [2:0] state;
        logic       fetchReq;
        logic       memReq;
        logic       instrLatch;
        logic       pcEnable;
        logic [2:0] branch;
        logic [1:0] jump;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic [4:0] aluOp;
        logic       aluSrc;
        logic       auipc;
        logic       lui;
        logic [2:0] dataWidth;
        logic       regWrite;
        logic       illegal;
        logic       halted;
        logic       busError;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       b6;
        logic       b0;
        logic       chk_alu;
        logic [4:0] alu;
        logic       src;
        logic [2:0] br;
        logic [1:0] jmp;
        logic       m2r;
        logic       lui;
        logic       auipc;
        logic [2:0] width;
        logic       rw;
        logic       ill;
        int         cycles;
        int         rd_cycles;
        int         wr_cycles;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7bit6;
    logic       funct7bit0;
    logic       ack_drv;
    logic       sel;
    logic       ack_a;
    logic       ack_b;

    logic [2:0] state_a, branch_a, width_a, state_b, branch_b, width_b;
    logic [1:0] jump_a, jump_b;
    logic [4:0] aluop_a, aluop_b;
    logic freq_a, mreq_a, latch_a, pcen_a, mrd_a, mwr_a, m2r_a, src_a;
    logic auipc_a, lui_a, rw_a, ill_a, halt_a, berr_a;
    logic freq_b, mreq_b, latch_b, pcen_b, mrd_b, mwr_b, m2r_b, src_b;
    logic auipc_b, lui_b, rw_b, ill_b, halt_b, berr_b;

    outs_t obs_a, obs_b, so, reset_exp;

    int checks;
    int failures;
    int n_cycles, n_rw, n_pc, n_latch, n_ill, n_mreq, n_mrd, n_mwr;
    int end_state;
    outs_t wb_snap;
    vec_t vecs [15];

    assign ack_a = sel ? 1'b0 : ack_drv;
    assign ack_b = sel ? ack_drv : 1'b0;

    t03_mc_control dut_a (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct3(funct3),
        .funct7bit6(funct7bit6), .funct7bit0(funct7bit0), .ack(ack_a),
        .fetchReq(freq_a), .memReq(mreq_a), .instrLatch(latch_a), .pcEnable(pcen_a),
        .branch(branch_a), .jump(jump_a), .memRead(mrd_a), .memWrite(mwr_a),
        .memToReg(m2r_a), .ALUOp(aluop_a), .ALUsrc(src_a), .auipc(auipc_a),
        .lui(lui_a), .dataWidth(width_a), .regWrite(rw_a), .illegal(ill_a),
        .halted(halt_a), .busError(berr_a), .state(state_a)
    );

    t03_mc_control #(.ENABLE_M(0), .TIMEOUT(4), .HALT_ON_ZERO(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct3(funct3),
        .funct7bit6(funct7bit6), .funct7bit0(funct7bit0), .ack(ack_b),
        .fetchReq(freq_b), .memReq(mreq_b), .instrLatch(latch_b), .pcEnable(pcen_b),
        .branch(branch_b), .jump(jump_b), .memRead(mrd_b), .memWrite(mwr_b),
        .memToReg(m2r_b), .ALUOp(aluop_b), .ALUsrc(src_b), .auipc(auipc_b),
        .lui(lui_b), .dataWidth(width_b), .regWrite(rw_b), .illegal(ill_b),
        .halted(halt_b), .busError(berr_b), .state(state_b)
    );

    assign obs_a = {state_a, freq_a, mreq_a, latch_a, pcen_a, branch_a, jump_a, mrd_a, mwr_a,
                    m2r_a, aluop_a, src_a, auipc_a, lui_a, width_a, rw_a, ill_a, halt_a, berr_a};
    assign obs_b = {state_b, freq_b, mreq_b, latch_b, pcen_b, branch_b, jump_b, mrd_b, mwr_b,
                    m2r_b, aluop_b, src_b, auipc_b, lui_b, width_b, rw_b, ill_b, halt_b, berr_b};
    assign so = sel ? obs_b : obs_a;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the main sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Assert reset for two cycles and release it on a falling edge.
    task automatic doReset();
        rst = 1'b1;
        ack_drv = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Run one instruction from FETCH until the FSM returns to FETCH or stops,
    // answering fetch acks at once and data acks after mem_delay MWAIT cycles.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic b6,
                                 input logic b0, input int mem_delay);
        int  wait_cnt;
        bit  done;
        opcode = op;
        funct3 = f3;
        funct7bit6 = b6;
        funct7bit0 = b0;
        n_cycles = 0; n_rw = 0; n_pc = 0; n_latch = 0; n_ill = 0;
        n_mreq = 0; n_mrd = 0; n_mwr = 0;
        wb_snap = '0;
        end_state = -1;
        wait_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if ((n_cycles > 0 && so.state == 3'd0) || so.state == 3'd7) begin
                done = 1'b1;
                end_state = int'(so.state);
                break;
            end
            if (so.state == 3'd1) begin
                ack_drv = 1'b1;
            end else if (so.state == 3'd5) begin
                ack_drv = (wait_cnt >= mem_delay);
                wait_cnt++;
            end else begin
                ack_drv = 1'b0;
            end
            #1;
            n_cycles++;
            if (so.regWrite) n_rw++;
            if (so.pcEnable) n_pc++;
            if (so.instrLatch) n_latch++;
            if (so.illegal) n_ill++;
            if (so.memReq) n_mreq++;
            if (so.memRead) n_mrd++;
            if (so.memWrite) n_mwr++;
            if (so.state == 3'd6) wb_snap = so;
            @(negedge clk);
        end
        ack_drv = 1'b0;
        checkOutput("instr_completes", int'(done), 1);
    endtask

    // Hold ack low from FETCH and count FWAIT cycles until the bus error.
    task automatic timeoutCheck(input logic which, input int exp_wait);
        int fw;
        sel = which;
        doReset();
        opcode = 7'b0110011;
        funct3 = 3'd0;
        funct7bit6 = 1'b0;
        funct7bit0 = 1'b0;
        fw = 0;
        for (int c = 0; c < 64; c++) begin
            if (so.state == 3'd7) break;
            if (so.state == 3'd1) fw++;
            @(negedge clk);
        end
        #1;
        checkOutput($sformatf("to%0d_fwait_cycles", which), fw, exp_wait);
        checkOutput($sformatf("to%0d_state", which), int'(so.state), 7);
        checkOutput($sformatf("to%0d_buserror", which), int'(so.busError), 1);
        checkOutput($sformatf("to%0d_halted", which), int'(so.halted), 0);
        checkOutput($sformatf("to%0d_fetchreq", which), int'(so.fetchReq), 0);
        checkOutput($sformatf("to%0d_memreq", which), int'(so.memReq), 0);
        ack_drv = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput($sformatf("to%0d_absorbing", which), int'(so.state), 7);
        checkOutput($sformatf("to%0d_no_pc", which), int'(so.pcEnable), 0);
        ack_drv = 1'b0;
        doReset();
        #1;
        checkOutput($sformatf("to%0d_recover_state", which), int'(so.state), 0);
        checkOutput($sformatf("to%0d_recover_flag", which), int'(so.busError), 0);
    endtask

    initial begin
        int exp_seq [6];
        int exp_latch [6];
        int exp_pc [6];
        checks = 0;
        failures = 0;
        sel = 1'b0;
        ack_drv = 1'b0;
        en = 1'b1;
        rst = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        funct7bit6 = 1'b0;
        funct7bit0 = 1'b0;
        reset_exp = '0;
        reset_exp.branch = 3'b011;

        //           op          f3    b6    b0    chk   alu       src   br      jmp    m2r   lui   aui   w     rw    ill  cyc rd wr
        vecs[0]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[1]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 1'b1, 5'b01000, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[2]  = '{7'b0010011, 3'd5, 1'b1, 1'b0, 1'b1, 5'b01101, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[3]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[4]  = '{7'b0010011, 3'd4, 1'b1, 1'b0, 1'b1, 5'b00100, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[5]  = '{7'b0110011, 3'd0, 1'b0, 1'b1, 1'b1, 5'b10000, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[6]  = '{7'b0110011, 3'd3, 1'b1, 1'b1, 1'b1, 5'b10011, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[7]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 3'b011, 2'b00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 7, 2, 0};
        vecs[8]  = '{7'b0100011, 3'd1, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 7, 0, 2};
        vecs[9]  = '{7'b1100011, 3'd1, 1'b0, 1'b0, 1'b1, 5'b01000, 1'b0, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5, 0, 0};
        vecs[10] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 3'b011, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[11] = '{7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 3'b011, 2'b10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[12] = '{7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[13] = '{7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 5, 0, 0};
        vecs[14] = '{7'b1111111, 3'd3, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 4, 0, 0};

        #1;
        checkOutput("reset_outputs", int'(so), int'(reset_exp));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].b6, vecs[i].b0, 0);
            checkOutput($sformatf("v%0d_cycles", i), n_cycles, vecs[i].cycles);
            checkOutput($sformatf("v%0d_regwrite", i), n_rw, int'(vecs[i].rw));
            checkOutput($sformatf("v%0d_pcenable", i), n_pc, 1);
            checkOutput($sformatf("v%0d_instrlatch", i), n_latch, 1);
            checkOutput($sformatf("v%0d_illegal", i), n_ill, int'(vecs[i].ill));
            checkOutput($sformatf("v%0d_memread", i), n_mrd, vecs[i].rd_cycles);
            checkOutput($sformatf("v%0d_memwrite", i), n_mwr, vecs[i].wr_cycles);
            if (vecs[i].chk_alu) begin
                checkOutput($sformatf("v%0d_aluop", i), int'(wb_snap.aluOp), int'(vecs[i].alu));
            end
            checkOutput($sformatf("v%0d_alusrc", i), int'(wb_snap.aluSrc), int'(vecs[i].src));
            checkOutput($sformatf("v%0d_branch", i), int'(wb_snap.branch), int'(vecs[i].br));
            checkOutput($sformatf("v%0d_jump", i), int'(wb_snap.jump), int'(vecs[i].jmp));
            checkOutput($sformatf("v%0d_memtoreg", i), int'(wb_snap.memToReg), int'(vecs[i].m2r));
            checkOutput($sformatf("v%0d_lui", i), int'(wb_snap.lui), int'(vecs[i].lui));
            checkOutput($sformatf("v%0d_auipc", i), int'(wb_snap.auipc), int'(vecs[i].auipc));
            if (vecs[i].rd_cycles > 0 || vecs[i].wr_cycles > 0 || vecs[i].ill) begin
                checkOutput($sformatf("v%0d_width", i), int'(wb_snap.dataWidth), int'(vecs[i].width));
            end
        end

        // Reset in the middle of a fetch wait, then run ADD with ack tied high.
        opcode = 7'b0110011;
        funct3 = 3'd0;
        funct7bit6 = 1'b0;
        funct7bit0 = 1'b0;
        ack_drv = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("pre_reset_fwait", int'(so.state), 1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_outputs", int'(so), int'(reset_exp));
        @(negedge clk);
        #1;
        checkOutput("midreset_fetchreq_hold", int'(so.fetchReq), 0);
        ack_drv = 1'b1;
        rst = 1'b0;
        exp_seq   = '{0, 1, 2, 3, 6, 0};
        exp_latch = '{0, 1, 0, 0, 0, 0};
        exp_pc    = '{0, 0, 0, 0, 1, 0};
        for (int c = 0; c < 6; c++) begin
            #1;
            checkOutput($sformatf("seq_state_c%0d", c + 1), int'(so.state), exp_seq[c]);
            checkOutput($sformatf("seq_latch_c%0d", c + 1), int'(so.instrLatch), exp_latch[c]);
            checkOutput($sformatf("seq_pcen_c%0d", c + 1), int'(so.pcEnable), exp_pc[c]);
            checkOutput($sformatf("seq_regwr_c%0d", c + 1), int'(so.regWrite), exp_pc[c]);
            @(negedge clk);
        end
        doReset();

        // Load with the data ack arriving on the fourth MWAIT cycle.
        applyStimulus(7'b0000011, 3'd2, 1'b0, 1'b0, 3);
        checkOutput("lw_slow_cycles", n_cycles, 10);
        checkOutput("lw_slow_memreq", n_mreq, 5);
        checkOutput("lw_slow_memread", n_mrd, 5);
        checkOutput("lw_slow_memwrite", n_mwr, 0);
        checkOutput("lw_slow_regwrite", n_rw, 1);
        checkOutput("lw_slow_pcenable", n_pc, 1);
        checkOutput("lw_slow_memtoreg", int'(wb_snap.memToReg), 1);

        // Freeze with en=0 while in MWAIT (ack present) and again in WB.
        opcode = 7'b0000011;
        funct3 = 3'd2;
        ack_drv = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (so.state == 3'd5) break;
            @(negedge clk);
        end
        en = 1'b0;
        #1;
        checkOutput("freeze_entry_state", int'(so.state), 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("freeze_state_%0d", k), int'(so.state), 5);
            checkOutput($sformatf("freeze_memreq_%0d", k), int'(so.memReq), 1);
            checkOutput($sformatf("freeze_memread_%0d", k), int'(so.memRead), 1);
        end
        @(negedge clk);
        en = 1'b1;
        ack_drv = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("unfreeze_noack_state", int'(so.state), 5);
        ack_drv = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #1;
        checkOutput("wb_frozen_state", int'(so.state), 6);
        checkOutput("wb_frozen_regwrite", int'(so.regWrite), 0);
        checkOutput("wb_frozen_pcenable", int'(so.pcEnable), 0);
        @(negedge clk);
        #1;
        checkOutput("wb_frozen_hold", int'(so.state), 6);
        en = 1'b1;
        #1;
        checkOutput("wb_live_regwrite", int'(so.regWrite), 1);
        checkOutput("wb_live_pcenable", int'(so.pcEnable), 1);
        @(negedge clk);
        #1;
        checkOutput("wb_to_fetch", int'(so.state), 0);
        ack_drv = 1'b0;

        // Fetch timeouts on both configurations.
        timeoutCheck(1'b0, 16);
        timeoutCheck(1'b1, 4);

        // Opcode zero halts the default configuration.
        sel = 1'b0;
        doReset();
        applyStimulus(7'b0000000, 3'd0, 1'b0, 1'b0, 0);
        #1;
        checkOutput("halt_end_state", end_state, 7);
        checkOutput("halt_cycles", n_cycles, 3);
        checkOutput("halt_flag", int'(so.halted), 1);
        checkOutput("halt_buserror", int'(so.busError), 0);
        checkOutput("halt_no_pcenable", n_pc, 0);
        ack_drv = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("halt_absorbing", int'(so.state), 7);
        checkOutput("halt_fetchreq", int'(so.fetchReq), 0);
        ack_drv = 1'b0;

        // Second configuration: M ops illegal, opcode zero is a NOP.
        sel = 1'b1;
        doReset();
        applyStimulus(7'b0110011, 3'd0, 1'b0, 1'b1, 0);
        checkOutput("nom_mul_cycles", n_cycles, 4);
        checkOutput("nom_mul_illegal", n_ill, 1);
        checkOutput("nom_mul_regwrite", n_rw, 0);
        checkOutput("nom_mul_pcenable", n_pc, 1);
        checkOutput("nom_mul_aluop", int'(wb_snap.aluOp), 0);
        applyStimulus(7'b0110011, 3'd0, 1'b1, 1'b0, 0);
        checkOutput("nom_sub_regwrite", n_rw, 1);
        checkOutput("nom_sub_illegal", n_ill, 0);
        checkOutput("nom_sub_aluop", int'(wb_snap.aluOp), 8);
        applyStimulus(7'b0000000, 3'd0, 1'b0, 1'b0, 0);
        #1;
        checkOutput("nop_cycles", n_cycles, 5);
        checkOutput("nop_end_state", end_state, 0);
        checkOutput("nop_regwrite", n_rw, 0);
        checkOutput("nop_illegal", n_ill, 0);
        checkOutput("nop_halted", int'(so.halted), 0);
        checkOutput("nop_branch", int'(wb_snap.branch), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
